// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit. A Moore FSM sequences fetch, decode,
// execute, memory and write-back for the shared-memory multicycle datapath.
// A memory-ready handshake is guarded by a watchdog counter. Illegal
// opcodes and memory timeouts both divert through a one-cycle FAULT state.
// Optional feature: define MIPS_CTRL_JUMP_EN to decode opcode 000010 as j.
// Without it, j is illegal and PCSource never drives 10.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 15,  // max consecutive wait cycles, 0 = no watchdog
  parameter int CNT_W       = 4    // 2**CNT_W must exceed MEM_TIMEOUT
) (
  input  logic       CLK,
  input  logic       Reset,        // asynchronous, active low
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Fault,
  output logic       FaultCause,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
`ifdef MIPS_CTRL_JUMP_EN
    S_JUMP   = 4'd11,
`endif
    S_FAULT  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MIPS_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  state_e             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cause_q, cause_d;
  logic               mem_state;
  logic               timeout;

  // Next-state, opcode capture, wait counter and fault-cause update.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    op_d    = op_q;
    cause_d = cause_q;

    mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A completing access on the last allowed cycle wins over the watchdog.
    timeout   = (MEM_TIMEOUT != 0) && !MemReady && (cnt_q == CNT_W'(MEM_TIMEOUT));

    unique case (state_q)
      S_FETCH: begin
        if (MemReady)     state_d = S_DECODE;
        else if (timeout) begin
          state_d = S_FAULT;
          cause_d = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = Opcode;
        unique case (Opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
          OP_J:          state_d = S_JUMP;
`endif
          default: begin
            state_d = S_FAULT;
            cause_d = 1'b0;
          end
        endcase
      end
      // Only lw and sw reach MEMADR, so anything but lw is a store.
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (MemReady)     state_d = S_MEMWB;
        else if (timeout) begin
          state_d = S_FAULT;
          cause_d = 1'b1;
        end
      end
      S_MEMWR: begin
        if (MemReady)     state_d = S_FETCH;
        else if (timeout) begin
          state_d = S_FAULT;
          cause_d = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;  // write-back, branch, jump, fault, unused codes
    endcase

    // Staying in a memory state means the access is still waiting; any
    // state change (entry, completion, fault) restarts the count from zero.
    cnt_d = (mem_state && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
  end

  // State registers; reset abandons any instruction in flight.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      cause_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from values sampled before the edge.
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Moore output decode from the current state, with MemReady gating in FETCH.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    Fault       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`endif
      S_FAULT: Fault = 1'b1;
      default: ;
    endcase
  end

  assign FaultCause = cause_q;
  assign State      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control. A per-instruction reference
// model expands each instruction into the cycles it should occupy. It pushes
// input stimulus and expected outputs into two queues. A driver replays the
// stimulus while a separate monitor compares outputs each cycle.
module tb_mips_multicycle_control;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  logic       CLK, Reset, MemReady;
  logic [5:0] Opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Fault, FaultCause;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  mips_multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Fault(Fault), .FaultCause(FaultCause),
    .State(State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observable bundle compared every cycle.
  typedef struct packed {
    logic [3:0] state;
    logic       fault, fault_cause;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
  } obs_t;

  typedef struct packed {
    logic       rdy;
    logic [5:0] op;
  } stim_t;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
                P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP, P_FAULT} phase_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;
  bit    go    = 0;
  logic  model_cause = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // What the datapath should see during one cycle of a given phase.
  function automatic obs_t expect_of(input phase_t p, input logic rdy, input logic cause);
    obs_t e;
    e = '0;
    e.fault_cause = cause;
    case (p)
      P_FETCH:  begin e.state = 4'd0;  e.mem_read = 1; e.alu_src_b = 2'b01;
                      e.ir_write = rdy; e.pc_write = rdy; end
      P_DECODE: begin e.state = 4'd1;  e.alu_src_b = 2'b11; end
      P_MEMADR: begin e.state = 4'd2;  e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      P_MEMRD:  begin e.state = 4'd3;  e.mem_read = 1; e.iord = 1; end
      P_MEMWB:  begin e.state = 4'd4;  e.reg_write = 1; e.mem_to_reg = 1; end
      P_MEMWR:  begin e.state = 4'd5;  e.mem_write = 1; e.iord = 1; end
      P_EXEC:   begin e.state = 4'd6;  e.alu_src_a = 1; e.alu_op = 2'b10; end
      P_ALUWB:  begin e.state = 4'd7;  e.reg_dst = 1; e.reg_write = 1; end
      P_BRANCH: begin e.state = 4'd8;  e.alu_src_a = 1; e.alu_op = 2'b01;
                      e.pc_write_cond = 1; e.pc_source = 2'b01; end
      P_ADDIEX: begin e.state = 4'd9;  e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      P_ADDIWB: begin e.state = 4'd10; e.reg_write = 1; end
      P_JUMP:   begin e.state = 4'd11; e.pc_write = 1; e.pc_source = 2'b10; end
      P_FAULT:  begin e.state = 4'd12; e.fault = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // One cycle of stimulus and its expected observation. Opcode is random
  // outside DECODE to show it is ignored there.
  task automatic push(input phase_t p, input logic rdy, input logic [5:0] op);
    stim_t s;
    s.rdy = rdy;
    s.op  = (p == P_DECODE) ? op : 6'($urandom);
    stim_q.push_back(s);
    exp_q.push_back(expect_of(p, rdy, model_cause));
  endtask

  // A memory access that waits w cycles; longer than the watchdog faults.
  task automatic mem_phase(input phase_t p, input int w, output bit ok);
    if (MEM_TIMEOUT != 0 && w > MEM_TIMEOUT) begin
      repeat (MEM_TIMEOUT + 1) push(p, 1'b0, 6'h0);
      model_cause = 1'b1;
      push(P_FAULT, 1'($urandom), 6'h0);
      ok = 0;
    end else begin
      repeat (w) push(p, 1'b0, 6'h0);
      push(p, 1'b1, 6'h0);
      ok = 1;
    end
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bit ok;
    bit jump_en;
`ifdef MIPS_CTRL_JUMP_EN
    jump_en = 1;
`else
    jump_en = 0;
`endif
    mem_phase(P_FETCH, fw, ok);
    if (!ok) return;
    push(P_DECODE, 1'($urandom), op);
    if (op == OP_R) begin
      push(P_EXEC, 1'($urandom), 6'h0);
      push(P_ALUWB, 1'($urandom), 6'h0);
    end else if (op == OP_LW) begin
      push(P_MEMADR, 1'($urandom), 6'h0);
      mem_phase(P_MEMRD, mw, ok);
      if (ok) push(P_MEMWB, 1'($urandom), 6'h0);
    end else if (op == OP_SW) begin
      push(P_MEMADR, 1'($urandom), 6'h0);
      mem_phase(P_MEMWR, mw, ok);
    end else if (op == OP_BEQ) begin
      push(P_BRANCH, 1'($urandom), 6'h0);
    end else if (op == OP_ADDI) begin
      push(P_ADDIEX, 1'($urandom), 6'h0);
      push(P_ADDIWB, 1'($urandom), 6'h0);
    end else if (op == OP_J && jump_en) begin
      push(P_JUMP, 1'($urandom), 6'h0);
    end else begin
      model_cause = 1'b0;
      push(P_FAULT, 1'($urandom), 6'h0);
    end
  endtask

  function automatic int rand_wait();
    int k;
    int edge_w[4] = '{14, 15, 16, 22};
    k = $urandom_range(0, 15);
    if (k < 12) return $urandom_range(0, 3);
    return edge_w[k - 12];
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    int k;
    k = $urandom_range(0, 7);
    if (k < 6) return ops[k];
    return 6'($urandom);
  endfunction

  // Driver: replays queued stimulus shortly after each rising edge.
  initial begin
    stim_t s;
    forever begin
      @(posedge CLK);
      #2;
      if (go && stim_q.size() > 0) begin
        s = stim_q.pop_front();
        MemReady = s.rdy;
        Opcode   = s.op;
      end
    end
  end

  // Monitor: compares the DUT against the next expected cycle at each falling edge.
  initial begin
    obs_t act, e;
    forever begin
      @(negedge CLK);
      if (go && exp_q.size() > 0) begin
        act = '{state: State, fault: Fault, fault_cause: FaultCause,
                pc_write: PCWrite, pc_write_cond: PCWriteCond, iord: IorD,
                mem_read: MemRead, mem_write: MemWrite, ir_write: IRWrite,
                mem_to_reg: MemtoReg, reg_dst: RegDst, reg_write: RegWrite,
                alu_src_a: ALUSrcA, alu_src_b: ALUSrcB, alu_op: ALUOp,
                pc_source: PCSource};
        e = exp_q.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL cycle t=%0t: state got %0d want %0d, outputs got %h want %h",
                   $time, act.state, e.state, act, e);
        end
      end
    end
  end

  initial begin
    int n;
    Reset    = 1'b0;
    MemReady = 1'b0;
    Opcode   = 6'h00;

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", 32'(State), 32'd0);
    check("reset_fault", 32'(Fault), 32'd0);
    check("reset_cause", 32'(FaultCause), 32'd0);
    check("reset_memread", 32'(MemRead), 32'd1);
    check("reset_alusrcb", 32'(ALUSrcB), 32'd1);
    check("reset_irwrite", 32'(IRWrite), 32'd0);

    // Run an R-type into EXEC, then pull reset in the middle of it.
    @(posedge CLK);
    #1;
    Reset    = 1'b1;
    MemReady = 1'b1;
    Opcode   = OP_R;
    n = 0;
    while (State != 4'd6 && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("reach_exec", 32'(State), 32'd6);
    #2;
    MemReady = 1'b0;
    Reset    = 1'b0;
    #1;
    check("midreset_state", 32'(State), 32'd0);
    check("midreset_fault", 32'(Fault), 32'd0);
    check("midreset_memread", 32'(MemRead), 32'd1);
    check("midreset_memwrite", 32'(MemWrite), 32'd0);
    check("midreset_regwrite", 32'(RegWrite), 32'd0);
    check("midreset_pcwrite", 32'(PCWrite), 32'd0);

    // Directed instruction stream, then a randomized one.
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(6'h3F, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_R, 16, 0);
    run_instr(OP_ADDI, 15, 0);
    run_instr(OP_LW, 1, 15);
    run_instr(OP_LW, 0, 16);
    run_instr(OP_SW, 2, 16);
    run_instr(6'h3F, 0, 0);
    run_instr(OP_SW, 0, 15);
    for (int i = 0; i < 80; i++) run_instr(rand_op(), rand_wait(), rand_wait());

    @(posedge CLK);
    #1;
    Reset = 1'b1;
    go    = 1;

    n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      @(posedge CLK);
      n++;
    end
    @(posedge CLK);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expected cycles left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
